// File: rtl/bcd_seg_pkg.sv
// ---------------------------------------------------------------------------
// bcd_seg_pkg
//   Shared types and segment constants for the two-digit multiplexed
//   seven-segment driver (bcd_seg_scan) and its digit decoder (bcd_to_seg).
//
//   Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high.
// ---------------------------------------------------------------------------
package bcd_seg_pkg;

    // Which digit currently owns the shared segment bus.
    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } digit_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;   // g only
    localparam logic [6:0] SEG_E     = 7'h79;   // a,d,e,f,g

    // Standard decimal glyphs, index = digit value.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F   // 9
    };

endpackage

// File: rtl/bcd_seg_scan_if.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan_if
//   Bundles the BCD input word from the encoder stage with the multiplexed
//   display outputs of bcd_seg_scan.
//
//   bcd[4:0]  tens digit in bit 4, ones digit in bits 3:0
//   valid     bcd is meaningful
//   seg[6:0]  segments {g,f,e,d,c,b,a}, active-high
//   an[1:0]   one-hot digit enable (an[0] ones, an[1] tens)
//   err       held ones digit is out of range (> 9)
//
//   master : the side producing bcd/valid and watching the display
//   slave  : the display driver itself
// ---------------------------------------------------------------------------
interface bcd_seg_scan_if;

    logic [4:0] bcd;
    logic       valid;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    modport master (
        output bcd,
        output valid,
        input  seg,
        input  an,
        input  err
    );

    modport slave (
        input  bcd,
        input  valid,
        output seg,
        output an,
        output err
    );

endinterface

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
//   Combinational single-digit decoder.
//
//   digit[3:0] : digit value to render
//   blank      : render nothing (leading-zero suppression)
//   dash       : render a dash (no valid value held); overrides everything
//   seg[6:0]   : segment code {g,f,e,d,c,b,a}
//   oor        : digit is above 9 and is being rendered as 'E'
// ---------------------------------------------------------------------------
module bcd_to_seg
    import bcd_seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg,
    output logic       oor
);

    always_comb begin
        seg = SEG_BLANK;
        oor = 1'b0;
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else if (digit > 4'd9) begin
            seg = SEG_E;
            oor = 1'b1;
        end else begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan
//   Two-digit multiplexed seven-segment driver. A free-running divider
//   alternates the shared segment bus between the ones and tens digits,
//   each enabled for SCAN_DIV cycles. The BCD input is captured only at the
//   end of a full frame (after the tens digit), so a frame never shows a
//   mix of old and new values.
//
//   Parameters
//     SCAN_DIV      cycles each digit stays enabled (>= 2)
//     BLANK_LEADING 1: tens digit 0 is blanked, 0: shown as '0'
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   bcd_seg_scan_if.slave (bcd/valid in, seg/an/err out)
// ---------------------------------------------------------------------------
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    bcd_seg_scan_if.slave  bus
);

    generate
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("bcd_seg_scan: SCAN_DIV must be 2 or more");
        end
    endgenerate

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    digit_e           digit_q;

    logic             tens_h;
    logic [3:0]       ones_h;
    logic             valid_h;

    logic             at_wrap;
    logic             frame_end;

    logic [3:0]       dec_digit;
    logic             dec_blank;
    logic             dec_dash;
    logic [6:0]       dec_seg;
    logic             dec_oor;
    logic             err_d;

    logic [6:0]       seg_p1;
    logic [1:0]       an_p1;
    logic             err_p1;

    assign at_wrap   = (div_cnt == CNT_LAST);
    assign frame_end = at_wrap && (digit_q == DIG_TENS);

    // ---- stage 0: scan counter, digit FSM and frame capture --------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            digit_q <= DIG_ONES;
            tens_h  <= 1'b0;
            ones_h  <= 4'd0;
            valid_h <= 1'b0;
        end else begin
            if (at_wrap) begin
                div_cnt <= '0;
                case (digit_q)
                    DIG_ONES: digit_q <= DIG_TENS;
                    DIG_TENS: digit_q <= DIG_ONES;
                    default:  digit_q <= DIG_ONES;
                endcase
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end

            if (frame_end) begin
                tens_h  <= bus.bcd[4];
                ones_h  <= bus.bcd[3:0];
                valid_h <= bus.valid;
            end
        end
    end

    assign dec_digit = (digit_q == DIG_ONES) ? ones_h : {3'b000, tens_h};
    assign dec_blank = BLANK_LEADING && (digit_q == DIG_TENS) && !tens_h;
    assign dec_dash  = !valid_h;

    bcd_to_seg u_dec (
        .digit (dec_digit),
        .blank (dec_blank),
        .dash  (dec_dash),
        .seg   (dec_seg),
        .oor   (dec_oor)
    );

    // The decoder only sees the ones digit during the ones phase. The held
    // registers change only on the TENS->ONES wrap, so every frame starts
    // in the ones phase with fresh held data: refresh err there and keep it
    // through the tens phase. Net effect is err = valid_h && ones_h > 9.
    assign err_d = (digit_q == DIG_ONES) ? dec_oor : err_p1;

    // ---- stage 1: registered display outputs ----------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p1 <= SEG_BLANK;
            an_p1  <= 2'b00;
            err_p1 <= 1'b0;
        end else begin
            seg_p1 <= dec_seg;
            an_p1  <= (digit_q == DIG_ONES) ? 2'b01 : 2'b10;
            err_p1 <= err_d;
        end
    end

    assign bus.seg = seg_p1;
    assign bus.an  = an_p1;
    assign bus.err = err_p1;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg_scan
//   Two instances with SCAN_DIV=4: dut_a blanks the leading zero, dut_b
//   shows it. Stimulus pushes the hand-written expected output of every
//   cycle into a queue; the monitor pops one entry per clock and compares.
// ---------------------------------------------------------------------------
module tb_bcd_seg_scan;

    typedef struct {
        logic [9:0] a;     // {seg, an, err} expected from dut_a
        logic [9:0] b;     // {seg, an, err} expected from dut_b
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb[$];
    exp_t e_m;
    logic [9:0] got_a;
    logic [9:0] got_b;

    bcd_seg_scan_if bus_a ();
    bcd_seg_scan_if bus_b ();

    bcd_seg_scan #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    bcd_seg_scan #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per clock, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e_m   = sb.pop_front();
            got_a = {bus_a.seg, bus_a.an, bus_a.err};
            got_b = {bus_b.seg, bus_b.an, bus_b.err};
            n_cmp++;
            if (got_a !== e_m.a) begin
                n_bad++;
                $display("FAIL %s dut_a: got seg=%h an=%b err=%b, want seg=%h an=%b err=%b",
                         e_m.name, got_a[9:3], got_a[2:1], got_a[0],
                         e_m.a[9:3], e_m.a[2:1], e_m.a[0]);
            end
            n_cmp++;
            if (got_b !== e_m.b) begin
                n_bad++;
                $display("FAIL %s dut_b: got seg=%h an=%b err=%b, want seg=%h an=%b err=%b",
                         e_m.name, got_b[9:3], got_b[2:1], got_b[0],
                         e_m.b[9:3], e_m.b[2:1], e_m.b[0]);
            end
        end
    end

    // Drive one cycle of inputs and record what both outputs must show
    // after the following rising edge.
    task automatic cyc(input logic r, input logic [4:0] b, input logic v,
                       input logic [6:0] s_a, input logic [6:0] s_b,
                       input logic [1:0] an, input logic er, input string nm);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus_a.bcd   = b;
        bus_a.valid = v;
        bus_b.bcd   = b;
        bus_b.valid = v;
        e.a    = {s_a, an, er};
        e.b    = {s_b, an, er};
        e.name = nm;
        sb.push_back(e);
    endtask

    // One full frame (4 ones cycles, 4 tens cycles). Inputs are b_first for
    // the first 'sw' cycles and b_rest afterwards; the value driven in the
    // last cycle is what gets captured for the next frame.
    task automatic frame(input logic [4:0] b_first, input logic [4:0] b_rest,
                         input int sw, input logic v,
                         input logic [6:0] ones, input logic [6:0] tens_a,
                         input logic [6:0] tens_b, input logic er, input string nm);
        logic [4:0] b;
        for (int k = 1; k <= 8; k++) begin
            b = (k <= sw) ? b_first : b_rest;
            if (k <= 4)
                cyc(1'b0, b, v, ones, ones, 2'b01, er, nm);
            else
                cyc(1'b0, b, v, tens_a, tens_b, 2'b10, er, nm);
        end
    endtask

    initial begin
        bus_a.bcd   = 5'h15;
        bus_a.valid = 1'b1;
        bus_b.bcd   = 5'h15;
        bus_b.valid = 1'b1;

        // Reset held three cycles with a valid word present.
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 5'h15, 1'b1, 7'h00, 7'h00, 2'b00, 1'b0, "reset");

        // Nothing captured yet: dash on both digits. Load 15.
        frame(5'h15, 5'h15, 8, 1'b1, 7'h40, 7'h40, 7'h40, 1'b0, "dash_after_reset");
        // Shows 15. Load 07.
        frame(5'h07, 5'h07, 8, 1'b1, 7'h6D, 7'h06, 7'h06, 1'b0, "digits_15");
        // Shows 07: tens blanked on dut_a, '0' on dut_b. Load 03.
        frame(5'h03, 5'h03, 8, 1'b1, 7'h07, 7'h00, 7'h3F, 1'b0, "leading_blank_07");
        // Shows 03 although input moves to 09 two cycles in.
        frame(5'h03, 5'h09, 2, 1'b1, 7'h4F, 7'h00, 7'h3F, 1'b0, "no_tear_03");
        // Shows 09. Load 0C.
        frame(5'h0C, 5'h0C, 8, 1'b1, 7'h6F, 7'h00, 7'h3F, 1'b0, "after_tear_09");
        // Shows E with err for the whole frame. Load 02.
        frame(5'h02, 5'h02, 8, 1'b1, 7'h79, 7'h00, 7'h3F, 1'b1, "out_of_range_0C");
        // err drops; shows 02. Valid low at the boundary.
        frame(5'h13, 5'h13, 8, 1'b0, 7'h5B, 7'h00, 7'h3F, 1'b0, "err_cleared_02");
        // Invalid capture: dash frame. Load 18.
        frame(5'h18, 5'h18, 8, 1'b1, 7'h40, 7'h40, 7'h40, 1'b0, "valid_low_dash");

        // Shows 18, then reset lands in the tens phase.
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 5'h18, 1'b1, 7'h7F, 7'h7F, 2'b01, 1'b0, "pre_reset_ones_8");
        cyc(1'b0, 5'h18, 1'b1, 7'h06, 7'h06, 2'b10, 1'b0, "pre_reset_tens_1");
        cyc(1'b1, 5'h18, 1'b1, 7'h00, 7'h00, 2'b00, 1'b0, "mid_frame_reset");

        // Held value discarded: dash again, scan restarts on ones. Load 10.
        frame(5'h10, 5'h10, 8, 1'b1, 7'h40, 7'h40, 7'h40, 1'b0, "dash_after_midreset");
        frame(5'h10, 5'h10, 8, 1'b1, 7'h3F, 7'h06, 7'h06, 1'b0, "digits_10");

        // Let the monitor drain the queue, bounded to a few cycles.
        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal end");
        $fatal(1, "watchdog");
    end

endmodule
